// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared types and elaboration-time helpers for the digit-serial adder/
// subtractor.
//   addsub_state_t : FSM state encoding (IDLE, RUN, DONE)
//   addsub_ndig    : number of digit slices per operation (WIDTH / DIGIT)
//   addsub_max     : most positive signed value for a given width
//   addsub_min     : most negative signed value for a given width
// The limit functions return 64-bit values; callers slice to WIDTH.
// -----------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } addsub_state_t;

   function automatic int addsub_ndig(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic logic [63:0] addsub_max(input int width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] addsub_min(input int width);
      return 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// -----------------------------------------------------------------------------
// addsub_digit
// Combinational DIGIT-bit ripple-carry slice.
//   x, y : DIGIT-bit addends
//   cin  : carry in
//   s    : DIGIT-bit sum
//   cout : carry out of the top bit
// -----------------------------------------------------------------------------
import addsub_pkg::*;

module addsub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < DIGIT; gi++) begin : g_bit
         assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
         assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
      end
   endgenerate

   assign cout = c[DIGIT];

endmodule

// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
// Digit-serial signed adder/subtractor, LSB digit first, one DIGIT-bit slice
// per clock, with valid/ready handshakes on input and output.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, op sampled on accept)
//   a, b                : WIDTH-bit signed operands
//   op                  : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake
//   sum                 : WIDTH-bit signed result, held while out_valid
//   ov                  : signed overflow of the operation
// Optional build macro ADDSUB_SAT_EN: on overflow, sum is clamped to the
// signed limit in the direction of a's sign; otherwise sum wraps.
// -----------------------------------------------------------------------------
import addsub_pkg::*;

module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             ov
);

   localparam int NDIG  = addsub_ndig(WIDTH, DIGIT);
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

   generate
      if ((WIDTH < 2) || (WIDTH > 64) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
         $error("addsub_serial: WIDTH must be 2..64 and a multiple of DIGIT");
      end
   endgenerate

   addsub_state_t    state_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;        // already inverted for subtraction
   logic             carry_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] res_reg;
   logic             ov_reg;
   logic             sign_a_reg;
   logic             sign_b_reg;   // sign of the effective (possibly inverted) b
   logic             in_ready_reg;
   logic             out_valid_reg;

   logic [DIGIT-1:0] digit_s;
   logic             digit_cout;
   logic [WIDTH-1:0] res_shift;
   logic [WIDTH-1:0] res_final;
   logic             ov_calc;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x    (a_reg[DIGIT-1:0]),
      .y    (b_reg[DIGIT-1:0]),
      .cin  (carry_reg),
      .s    (digit_s),
      .cout (digit_cout)
   );

   // New digit enters from the MSB side; after NDIG shifts digit 0 sits at LSB.
   generate
      if (NDIG == 1) begin : g_one_digit
         assign res_shift = digit_s;
      end else begin : g_multi_digit
         assign res_shift = {digit_s, res_reg[WIDTH-1:DIGIT]};
      end
   endgenerate

   // Only meaningful on the last digit, when res_shift holds the full result.
   assign ov_calc = (sign_a_reg == sign_b_reg) && (res_shift[WIDTH-1] != sign_a_reg);

`ifdef ADDSUB_SAT_EN
   localparam logic [63:0]      SAT_MAX64 = addsub_max(WIDTH);
   localparam logic [63:0]      SAT_MIN64 = addsub_min(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN64[WIDTH-1:0];

   // Overflow always points the way of a's sign, so that picks the limit.
   assign res_final = ov_calc ? (sign_a_reg ? SAT_MIN : SAT_MAX) : res_shift;
`else
   assign res_final = res_shift;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         carry_reg     <= 1'b0;
         cnt_reg       <= '0;
         res_reg       <= '0;
         ov_reg        <= 1'b0;
         sign_a_reg    <= 1'b0;
         sign_b_reg    <= 1'b0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               in_ready_reg <= 1'b1;
               if (in_valid && in_ready_reg) begin
                  a_reg        <= a;
                  b_reg        <= op ? ~b : b;
                  carry_reg    <= op;        // +1 completes the two's-complement negate
                  sign_a_reg   <= a[WIDTH-1];
                  sign_b_reg   <= op ? ~b[WIDTH-1] : b[WIDTH-1];
                  cnt_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= RUN;
               end
            end
            RUN: begin
               a_reg     <= a_reg >> DIGIT;
               b_reg     <= b_reg >> DIGIT;
               carry_reg <= digit_cout;
               cnt_reg   <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_DIG) begin
                  res_reg       <= res_final;
                  ov_reg        <= ov_calc;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  res_reg <= res_shift;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign sum       = res_reg;
   assign ov        = ov_reg;

endmodule

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
// Three instances: 16/4 (directed, back-pressure, reset mid-run), 4/2
// (exhaustive against an integer golden model) and 8/8 (single-digit case).
// Stimulus pushes expected results into per-instance queues; a monitor thread
// pops and compares whenever a result is presented.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [15:0] sum;
      logic        ov;
      int          acc;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [15:0] s_wrap;
      logic [15:0] s_sat;
      logic        ov;
   } vec_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   logic [2:0]  rst_v;
   logic [2:0]  in_valid_v;
   logic [2:0]  in_ready_v;
   logic [2:0]  out_valid_v;
   logic [2:0]  out_ready_v;
   logic [2:0]  op_v;
   logic [2:0]  ov_v;
   logic [15:0] a0, b0, sum0;
   logic [3:0]  a1, b1, sum1;
   logic [7:0]  a2, b2, sum2;

   exp_t        sb_q[3][$];
   logic [2:0]  seen;
   int          hs_cyc[3];
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[9];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut0 (
      .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a0), .b(b0), .op(op_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .sum(sum0), .ov(ov_v[0]));

   addsub_serial #(.WIDTH(4), .DIGIT(2)) u_dut1 (
      .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a1), .b(b1), .op(op_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .sum(sum1), .ov(ov_v[1]));

   addsub_serial #(.WIDTH(8), .DIGIT(8)) u_dut2 (
      .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a2), .b(b2), .op(op_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .sum(sum2), .ov(ov_v[2]));

   function automatic int ndig(input int k);
      case (k)
         0:       return 4;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [15:0] get_sum(input int k);
      case (k)
         0:       return sum0;
         1:       return {12'h000, sum1};
         default: return {8'h00, sum2};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic send(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input logic opv, input logic [15:0] es, input logic eov,
                       output int acc);
      int   t;
      exp_t e;
      t = 0;
      @(negedge clk);
      case (k)
         0:       begin a0 = av;      b0 = bv;      end
         1:       begin a1 = av[3:0]; b1 = bv[3:0]; end
         default: begin a2 = av[7:0]; b2 = bv[7:0]; end
      endcase
      op_v[k]       = opv;
      in_valid_v[k] = 1'b1;
      while (!in_ready_v[k] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready_v[k]) begin
         check($sformatf("dut%0d_accept_timeout", k), 32'(in_ready_v[k]), 32'd1);
         in_valid_v[k] = 1'b0;
         acc = -1;
         return;
      end
      acc   = cyc + 1;
      e.sum = es;
      e.ov  = eov;
      e.acc = acc;
      sb_q[k].push_back(e);
      @(negedge clk);
      in_valid_v[k] = 1'b0;
      $display("dut%0d op a=%0h b=%0h op=%0b expect sum=%0h ov=%0b accept@%0d",
               k, av, bv, opv, es, eov, acc);
   endtask

   task automatic wait_idle(input int k);
      int t;
      t = 0;
      while (!in_ready_v[k] && t < 100) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("dut%0d_idle_timeout", k), 32'(in_ready_v[k]), 32'd1);
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (out_valid_v[k]) begin
               if (sb_q[k].size() == 0) begin
                  check($sformatf("dut%0d_spurious_out_valid", k), 32'd1, 32'd0);
               end else begin
                  e = sb_q[k][0];
                  if (!seen[k]) begin
                     check($sformatf("dut%0d_latency", k), 32'(cyc - e.acc), 32'(ndig(k)));
                     seen[k] = 1'b1;
                  end
                  check($sformatf("dut%0d_sum", k), 32'(get_sum(k)), 32'(e.sum));
                  check($sformatf("dut%0d_ov", k), 32'(ov_v[k]), 32'(e.ov));
                  check($sformatf("dut%0d_in_ready_busy", k), 32'(in_ready_v[k]), 32'd0);
                  if (out_ready_v[k]) begin
                     void'(sb_q[k].pop_front());
                     seen[k]   = 1'b0;
                     hs_cyc[k] = cyc + 1;
                  end
               end
            end
         end
      end
   endtask

   initial begin
      int acc1, acc2, t, sa, sb, res, ovx, es;

      vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b1};
      vecs[1] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0};
      vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1};
      vecs[5] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
      vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h2345, 1'b0};
      vecs[7] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0};
      vecs[8] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 16'h7FFF, 1'b1};

      rst_v       = 3'b111;
      in_valid_v  = 3'b000;
      out_ready_v = 3'b111;
      op_v        = 3'b000;
      seen        = 3'b000;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
      for (int k = 0; k < 3; k++) hs_cyc[k] = 0;

      fork
         monitor_loop();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("dut%0d_rst_in_ready", k), 32'(in_ready_v[k]), 32'd0);
         check($sformatf("dut%0d_rst_out_valid", k), 32'(out_valid_v[k]), 32'd0);
         check($sformatf("dut%0d_rst_sum", k), 32'(get_sum(k)), 32'd0);
         check($sformatf("dut%0d_rst_ov", k), 32'(ov_v[k]), 32'd0);
      end
      rst_v = 3'b000;
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         check($sformatf("dut%0d_in_ready_after_rst", k), 32'(in_ready_v[k]), 32'd1);

      // Directed vectors, 16/4
      for (int i = 0; i < 9; i++)
         send(0, vecs[i].a, vecs[i].b, vecs[i].op,
              SAT ? vecs[i].s_sat : vecs[i].s_wrap, vecs[i].ov, acc1);

      // Back-pressure: stall the first result 5+ cycles while a second op waits
      wait_idle(0);
      out_ready_v[0] = 1'b0;
      send(0, 16'h0100, 16'h00FF, 1'b0, 16'h01FF, 1'b0, acc1);
      fork
         send(0, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b0, acc2);
         begin
            t = 0;
            while (!out_valid_v[0] && t < 50) begin
               @(negedge clk);
               t++;
            end
            repeat (5) @(negedge clk);
            @(posedge clk);
            #1 out_ready_v[0] = 1'b1;
         end
      join
      check("bp_accept_after_handshake", 32'(acc2), 32'(hs_cyc[0] + 1));

      // Reset on the second RUN cycle discards the operation
      wait_idle(0);
      a0 = 16'h1234; b0 = 16'h0001; op_v[0] = 1'b0;
      in_valid_v[0] = 1'b1;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      @(negedge clk);
      rst_v[0] = 1'b1;
      @(negedge clk);
      check("midrun_rst_out_valid", 32'(out_valid_v[0]), 32'd0);
      check("midrun_rst_sum", 32'(sum0), 32'd0);
      check("midrun_rst_ov", 32'(ov_v[0]), 32'd0);
      check("midrun_rst_in_ready", 32'(in_ready_v[0]), 32'd0);
      rst_v[0] = 1'b0;
      @(negedge clk);
      check("midrun_in_ready_after_rst", 32'(in_ready_v[0]), 32'd1);
      send(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, acc1);

      // Exhaustive 4/2 against an integer golden model
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int oi = 0; oi < 2; oi++) begin
               sa  = (ai >= 8) ? ai - 16 : ai;
               sb  = (bi >= 8) ? bi - 16 : bi;
               res = (oi != 0) ? sa - sb : sa + sb;
               ovx = ((res > 7) || (res < -8)) ? 1 : 0;
               es  = res & 15;
               if (SAT && ovx != 0) es = (sa < 0) ? 8 : 7;
               send(1, 16'(ai), 16'(bi), oi[0], 16'(es), ovx[0], acc1);
            end
         end
      end

      // Single-digit 8/8: -128 + -1
      send(2, 16'h0080, 16'h00FF, 1'b0, SAT ? 16'h0080 : 16'h007F, 1'b1, acc1);

      // Drain
      t = 0;
      while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      for (int k = 0; k < 3; k++)
         check($sformatf("dut%0d_drain_pending", k), 32'(sb_q[k].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial signed two's-complement adder/subtractor with valid/ready handshakes on both sides. It computes WIDTH-bit a+b or a−b one DIGIT-bit slice per clock, LSB first, and reports signed overflow. It is the multi-width, pipelined-interface successor to the team's 4-bit combinational add/sub, for datapaths where area matters more than throughput.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥2.
- DIGIT, 4: bits processed per cycle; WIDTH % DIGIT must be 0. NDIG = WIDTH/DIGIT.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept operands
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- op  in  1  0 = a+b, 1 = a−b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  signed result
- ov  out  1  signed overflow of the operation

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid && in_ready, the unit latches a, b_eff = op ? ~b : b, carry = op, digit counter = 0, and goes to RUN.
- RUN: each cycle adds the low DIGIT bits of a and b_eff plus carry, shifts the digit into the result register from the MSB side, and shifts both operand registers right by DIGIT. The counter increments. On the cycle that processes digit NDIG−1 the unit goes to DONE.
- ov = (sign(a) == sign(b_eff)) && (sign(result) != sign(a)), using the latched operand signs.
- DONE: out_valid=1. sum and ov are held stable until out_valid && out_ready, then the unit returns to IDLE.
- in_ready=0 in RUN and DONE. There is no overlap of operations.
- in_valid is ignored outside IDLE. a, b and op are sampled only on the accept edge.
- Arithmetic is modulo 2^WIDTH unless saturation is compiled in.
- Corner cases:
  - min − min = 0, ov=0.
  - min + min = 0, ov=1.
  - 0 − min = min, ov=1.

## Timing
- Reset values:
  - state = IDLE, out_valid = 0, sum = 0, ov = 0, counter = 0.
  - in_ready = 0 while rst is high, and 1 on the first cycle after rst deasserts.
- Latency: out_valid rises NDIG cycles after the accept edge.
- Throughput with out_ready held high: one operation per NDIG+2 cycles (accept, NDIG RUN cycles, DONE/handshake, then back in IDLE).
- Back-pressure: DONE persists indefinitely while out_ready=0. No result is ever dropped or overwritten.
- Reset asserted in any state takes effect on the next edge: the operation in progress is discarded, and outputs return to their reset values.
- NDIG=1 (DIGIT=WIDTH) is legal: RUN lasts exactly one cycle.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- ADDSUB_SAT_EN defined: when the computed ov=1, sum is clamped.
  - sign(a)=0 clamps to 2^(WIDTH−1)−1.
  - sign(a)=1 clamps to −2^(WIDTH−1).
  - ov still reports 1. Clamping is applied when entering DONE; latency is unchanged.
- ADDSUB_SAT_EN undefined: sum wraps modulo 2^WIDTH, and no clamp logic is generated.

## Structure
- Package addsub_pkg contains:
  - state enum type addsub_state_t (IDLE, RUN, DONE).
  - function addsub_ndig(WIDTH, DIGIT).
  - saturation-limit functions addsub_max(WIDTH) and addsub_min(WIDTH).
- Sub-module addsub_digit: combinational DIGIT-bit ripple slice with ports x, y, cin, s, cout. It is instantiated once in addsub_serial.
- Elaboration-time check: WIDTH % DIGIT == 0, WIDTH ≥ 2.

## Test plan
- WIDTH=16, DIGIT=4, no SAT: a=0x7FFF, b=0x0001, op=0 → sum=0x8000, ov=1, out_valid exactly 4 cycles after accept. With SAT: sum=0x7FFF, ov=1.
- a=0x8000, b=0x0001, op=1 → sum=0x7FFF, ov=1. With SAT: sum=0x8000. Also a=0xFFFF, b=0xFFFF, op=1 → sum=0, ov=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → sum/ov stable, in_ready=0 throughout, and the new in_valid is not accepted until one cycle after the out handshake.
- Reset mid-RUN: assert rst on the second RUN cycle → next cycle out_valid=0, sum=0, ov=0. After rst drops, in_ready=1 and the next operation (3+4, op=0) returns 7.
- Exhaustive WIDTH=4, DIGIT=2: all 512 {a,b,op} combinations against a golden model (golden sum = op ? a−b : a+b; sign-based overflow rule) → zero mismatches, each with latency 2.
- NDIG=1 (WIDTH=8, DIGIT=8): −128 + −1 → sum=0x7F, ov=1, out_valid one cycle after accept.
